// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port unified memory between IF and DM.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN alternates the winner on ties.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_nRD,
    output logic              mem_nWR,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       owner_dm;
    logic       op_wr;
    logic       last_owner;
    logic       prio_dm;
    logic       pick_dm;
    logic       pick_wr;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign prio_dm = ~last_owner;
`else
    // last_owner is still tracked, but DM always wins a tie here
    assign prio_dm = last_owner | 1'b1;
`endif

    assign pick_dm = dm_req & (~if_req | prio_dm);
    assign pick_wr = pick_dm & dm_we;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            cnt        <= '0;
            owner_dm   <= 1'b0;
            op_wr      <= 1'b0;
            last_owner <= 1'b1;
            if_gnt     <= 1'b0;
            dm_gnt     <= 1'b0;
            if_done    <= 1'b0;
            dm_done    <= 1'b0;
            busy       <= 1'b0;
            mem_nRD    <= 1'b1;
            mem_nWR    <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        owner_dm   <= pick_dm;
                        last_owner <= pick_dm;
                        op_wr      <= pick_wr;
                        mem_addr   <= pick_dm ? dm_addr : if_addr;
                        if (pick_wr)
                            mem_wdata <= dm_wdata;
                        cnt     <= CNT_INIT;
                        if_gnt  <= ~pick_dm;
                        dm_gnt  <= pick_dm;
                        busy    <= 1'b1;
                        mem_nRD <= pick_wr;
                        mem_nWR <= ~pick_wr;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (!op_wr) begin
                            if (owner_dm)
                                dm_rdata <= mem_rdata;
                            else
                                if_rdata <= mem_rdata;
                        end
                        if_gnt  <= 1'b0;
                        dm_gnt  <= 1'b0;
                        mem_nRD <= 1'b1;
                        mem_nWR <= 1'b1;
                        if_done <= ~owner_dm;
                        dm_done <= owner_dm;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if_done <= 1'b0;
                    dm_done <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter at MEM_LAT=2 and MEM_LAT=1.
// Tie expectations follow MEM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_arbiter;

    localparam logic [6:0] S_IDLE = 7'b0000011;
    localparam logic [6:0] S_IFRD = 7'b1000101;
    localparam logic [6:0] S_DMRD = 7'b0100101;
    localparam logic [6:0] S_DMWR = 7'b0100110;
    localparam logic [6:0] S_IFDN = 7'b0010111;
    localparam logic [6:0] S_DMDN = 7'b0001111;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    logic        if_req = 0, dm_req = 0, dm_we = 0;
    logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
    logic        if_gnt, if_done, dm_gnt, dm_done, mem_nRD, mem_nWR, busy;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    logic        b_if_req = 0;
    logic [31:0] b_if_addr = 0, b_mem_rdata = 0;
    logic        b_if_gnt, b_if_done, b_dm_gnt, b_dm_done;
    logic        b_nRD, b_nWR, b_busy;
    logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;

    logic [6:0] st, b_st;
    assign st = {if_gnt, dm_gnt, if_done, dm_done, busy, mem_nRD, mem_nWR};
    assign b_st = {b_if_gnt, b_dm_gnt, b_if_done, b_dm_done, b_busy, b_nRD, b_nWR};

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_dm_rd = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_done(dm_done),
        .dm_rdata(dm_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_nRD(mem_nRD), .mem_nWR(mem_nWR), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_l1 (
        .CLK(CLK), .nRST(nRST),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_done(b_if_done), .if_rdata(b_if_rdata),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0),
        .dm_wdata(32'h0), .dm_gnt(b_dm_gnt), .dm_done(b_dm_done),
        .dm_rdata(b_dm_rdata), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_nRD(b_nRD), .mem_nWR(b_nWR),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    task automatic test_reset();
        @(negedge CLK);
        checks++;
        if (st !== S_IDLE) begin
            errors++; $display("FAIL reset_ctl: got %b exp %b", st, S_IDLE);
        end
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h exp 0", mem_addr,
                     mem_wdata, if_rdata, dm_rdata);
        end
        checks++;
        if (b_st !== S_IDLE) begin
            errors++; $display("FAIL reset_l1: got %b exp %b", b_st, S_IDLE);
        end
        nRST = 1'b1;
    endtask

    task automatic test_if_read();
        if_addr = 32'h10; if_req = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge CLK);
            checks++;
            if (st !== S_IFRD || mem_addr !== 32'h10) begin
                errors++;
                $display("FAIL if_access c%0d: got %b %h exp %b 10",
                         c, st, mem_addr, S_IFRD);
            end
            mem_rdata = 32'h20010005;
        end
        @(negedge CLK);
        checks++;
        if (st !== S_IFDN || if_rdata !== 32'h20010005) begin
            errors++;
            $display("FAIL if_done: got %b %h exp %b 20010005",
                     st, if_rdata, S_IFDN);
        end
        if_req = 1'b0;
        @(negedge CLK);
        checks++;
        if (st !== S_IDLE) begin
            errors++; $display("FAIL if_idle: got %b exp %b", st, S_IDLE);
        end
    endtask

    task automatic test_tie();
        bit          own_dm [3];
        int          if_left = 2;
        logic [31:0] exp_if = 0;
        logic [31:0] rd;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        own_dm[0] = 0; own_dm[1] = 1; own_dm[2] = 0;
`else
        own_dm[0] = 1; own_dm[1] = 0; own_dm[2] = 0;
`endif
        @(negedge CLK);
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        exp_dm_rd = 0;
        dm_we = 0; dm_addr = 32'h40; if_addr = 32'h20;
        if_req = 1; dm_req = 1;
        for (int k = 0; k < 3; k++) begin
            rd = 32'hA000_0000 + 32'(k);
            for (int c = 1; c <= 2; c++) begin
                @(negedge CLK);
                checks++;
                if (st !== (own_dm[k] ? S_DMRD : S_IFRD) ||
                    mem_addr !== (own_dm[k] ? 32'h40 : 32'h20)) begin
                    errors++;
                    $display("FAIL tie_access k%0d c%0d: got %b %h exp owner_dm=%0d",
                             k, c, st, mem_addr, own_dm[k]);
                end
                mem_rdata = rd;
            end
            @(negedge CLK);
            if (own_dm[k]) begin
                exp_dm_rd = rd;
                dm_req = 0;
            end else begin
                exp_if = rd;
                if_left--;
                if (if_left == 0) if_req = 0;
            end
            checks++;
            if (st !== (own_dm[k] ? S_DMDN : S_IFDN) ||
                if_rdata !== exp_if || dm_rdata !== exp_dm_rd) begin
                errors++;
                $display("FAIL tie_done k%0d: got %b %h %h exp owner_dm=%0d %h %h",
                         k, st, if_rdata, dm_rdata, own_dm[k], exp_if, exp_dm_rd);
            end
            @(negedge CLK);
            checks++;
            if (st !== S_IDLE) begin
                errors++; $display("FAIL tie_idle k%0d: got %b exp %b", k, st, S_IDLE);
            end
        end
    endtask

    task automatic test_dm_store();
        dm_req = 1; dm_we = 1; dm_addr = 32'h1C; dm_wdata = 32'hDEADBEEF;
        mem_rdata = 32'h5555_5555;
        for (int c = 1; c <= 2; c++) begin
            @(negedge CLK);
            checks++;
            if (st !== S_DMWR || mem_addr !== 32'h1C ||
                mem_wdata !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL st_access c%0d: got %b %h %h exp %b 1c deadbeef",
                         c, st, mem_addr, mem_wdata, S_DMWR);
            end
        end
        @(negedge CLK);
        checks++;
        if (st !== S_DMDN || dm_rdata !== exp_dm_rd) begin
            errors++;
            $display("FAIL st_done: got %b %h exp %b %h",
                     st, dm_rdata, S_DMDN, exp_dm_rd);
        end
        dm_req = 0; dm_we = 0;
        @(negedge CLK);
        checks++;
        if (st !== S_IDLE) begin
            errors++; $display("FAIL st_idle: got %b exp %b", st, S_IDLE);
        end
    endtask

    task automatic test_reset_mid();
        if_addr = 32'h80; if_req = 1; mem_rdata = 32'h1234_5678;
        @(negedge CLK);
        checks++;
        if (st !== S_IFRD) begin
            errors++; $display("FAIL rm_access: got %b exp %b", st, S_IFRD);
        end
        @(negedge CLK);
        nRST = 0;
        #1;
        checks++;
        if (st !== S_IDLE || mem_addr !== 32'h0 || if_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rm_abort: got %b %h %h exp %b 0 0",
                     st, mem_addr, if_rdata, S_IDLE);
        end
        if_req = 0;
        @(negedge CLK);
        nRST = 1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge CLK);
            checks++;
            if (st !== S_IDLE) begin
                errors++; $display("FAIL rm_nodone c%0d: got %b exp %b", c, st, S_IDLE);
            end
        end
        if_addr = 32'h84; if_req = 1; mem_rdata = 32'hCAFEF00D;
        @(negedge CLK);
        checks++;
        if (st !== S_IFRD || mem_addr !== 32'h84) begin
            errors++;
            $display("FAIL rm_new_access: got %b %h exp %b 84", st, mem_addr, S_IFRD);
        end
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (st !== S_IFDN || if_rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL rm_new_done: got %b %h exp %b cafef00d",
                     st, if_rdata, S_IFDN);
        end
        if_req = 0;
        @(negedge CLK);
    endtask

    task automatic test_lat1();
        logic [31:0] rd;
        b_if_addr = 32'h100; b_if_req = 1;
        for (int k = 0; k < 2; k++) begin
            rd = 32'h0BAD_0001 + 32'(k);
            @(negedge CLK);
            checks++;
            if (b_st !== S_IFRD || b_mem_addr !== 32'h100 + 32'(4 * k)) begin
                errors++;
                $display("FAIL l1_access k%0d: got %b %h exp %b", k, b_st,
                         b_mem_addr, S_IFRD);
            end
            b_mem_rdata = rd;
            @(negedge CLK);
            checks++;
            if (b_st !== S_IFDN || b_if_rdata !== rd) begin
                errors++;
                $display("FAIL l1_done k%0d: got %b %h exp %b %h",
                         k, b_st, b_if_rdata, S_IFDN, rd);
            end
            b_if_addr = 32'h104;
            if (k == 1) b_if_req = 0;
            @(negedge CLK);
            checks++;
            if (b_st !== S_IDLE) begin
                errors++; $display("FAIL l1_idle k%0d: got %b exp %b", k, b_st, S_IDLE);
            end
        end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_tie();
        test_dm_store();
        test_reset_mid();
        test_lat1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: run exceeded time limit");
        $fatal(1);
    end

endmodule
